// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte-lane strobes, per-lane write priority,
// selectable 1/2-cycle read latency, read-valid flags and a saturating conflict counter.
module dual_port_ram_be #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 32,
    parameter int unsigned SETPRIORITY = 1,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned WRITE_FIRST = 0,
    parameter int unsigned CW          = 16
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            aEn,
    input  logic            aWrite,
    input  logic [AW-1:0]   aAddr,
    input  logic [DW/8-1:0] aStrb,
    input  logic [DW-1:0]   aWriteData,
    output logic [DW-1:0]   aReadData,
    output logic            aReadValid,
    input  logic            bEn,
    input  logic            bWrite,
    input  logic [AW-1:0]   bAddr,
    input  logic [DW/8-1:0] bStrb,
    input  logic [DW-1:0]   bWriteData,
    output logic [DW-1:0]   bReadData,
    output logic            bReadValid,
    output logic            conflict,
    output logic [CW-1:0]   conflictCount
);

    localparam int unsigned DEPTH  = 2 ** AW;
    localparam int unsigned NB     = DW / 8;
    localparam logic        B_WINS = (SETPRIORITY != 0);
    localparam logic        WF_BIT = (WRITE_FIRST != 0);

    logic [DW-1:0] mem [DEPTH];

    logic          aWrEn;
    logic          bWrEn;
    logic          sameAddr;
    logic          collide;
    logic [DW-1:0] aOld;
    logic [DW-1:0] bOld;
    logic [DW-1:0] aFinal;
    logic [DW-1:0] bFinal;

    assign aWrEn    = aEn & aWrite;
    assign bWrEn    = bEn & bWrite;
    assign sameAddr = aWrEn & bWrEn & (aAddr == bAddr);
    assign collide  = sameAddr & (|(aStrb & bStrb));
    assign aOld     = mem[aAddr];
    assign bOld     = mem[bAddr];

    // Per-lane merge: on a same-address collision both ports see one shared merged word.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic       bTakes;
        logic [7:0] colByte;

        assign bTakes  = bStrb[i] & (B_WINS | ~aStrb[i]);
        assign colByte = bTakes   ? bWriteData[8*i +: 8] :
                         aStrb[i] ? aWriteData[8*i +: 8] : aOld[8*i +: 8];

        assign aFinal[8*i +: 8] = sameAddr ? colByte :
                                  (aStrb[i] ? aWriteData[8*i +: 8] : aOld[8*i +: 8]);
        assign bFinal[8*i +: 8] = sameAddr ? colByte :
                                  (bStrb[i] ? bWriteData[8*i +: 8] : bOld[8*i +: 8]);
    end

    // Storage is never reset; writes are simply held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rstN) begin
            if (aWrEn) mem[aAddr] <= aFinal;
            if (bWrEn) mem[bAddr] <= bFinal;
        end
    end

    logic          aValid1;
    logic          bValid1;
    logic [DW-1:0] aData1;
    logic [DW-1:0] bData1;

    // First output stage; data registers only load on a returning access.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            aValid1       <= 1'b0;
            bValid1       <= 1'b0;
            aData1        <= '0;
            bData1        <= '0;
            conflict      <= 1'b0;
            conflictCount <= '0;
        end else begin
            aValid1  <= aEn & (~aWrite | WF_BIT);
            bValid1  <= bEn & (~bWrite | WF_BIT);
            conflict <= collide;
            if (aEn && !aWrite)       aData1 <= aOld;
            else if (aWrEn && WF_BIT) aData1 <= aFinal;
            if (bEn && !bWrite)       bData1 <= bOld;
            else if (bWrEn && WF_BIT) bData1 <= bFinal;
            if (collide && (conflictCount != '1)) conflictCount <= conflictCount + CW'(1);
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic          aValid2;
        logic          bValid2;
        logic [DW-1:0] aData2;
        logic [DW-1:0] bData2;

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                aValid2 <= 1'b0;
                bValid2 <= 1'b0;
                aData2  <= '0;
                bData2  <= '0;
            end else begin
                aValid2 <= aValid1;
                bValid2 <= bValid1;
                if (aValid1) aData2 <= aData1;
                if (bValid1) bData2 <= bData1;
            end
        end

        assign aReadData  = aData2;
        assign bReadData  = bData2;
        assign aReadValid = aValid2;
        assign bReadValid = bValid2;
    end else begin : g_lat1
        assign aReadData  = aData1;
        assign bReadData  = bData1;
        assign aReadValid = aValid1;
        assign bReadValid = bValid1;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two differently configured instances share one stimulus
// stream and are checked against a per-instance behavioural memory model.
module tb_dual_port_ram_be;

    localparam int PRI  [2] = '{1, 0};
    localparam int LAT  [2] = '{1, 2};
    localparam int WF   [2] = '{0, 1};
    localparam int CMAX [2] = '{65535, 3};

    logic        clk = 1'b0;
    logic        rstN;
    logic        aEn, aWrite, bEn, bWrite;
    logic [7:0]  aAddr, bAddr;
    logic [3:0]  aStrb, bStrb;
    logic [31:0] aWd, bWd;

    logic [31:0] aRd [2];
    logic [31:0] bRd [2];
    logic        aRv [2];
    logic        bRv [2];
    logic        conf [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.AW(8), .DW(32), .SETPRIORITY(1), .READ_LAT(1), .WRITE_FIRST(0), .CW(16)) u0 (
        .clk(clk), .rstN(rstN),
        .aEn(aEn), .aWrite(aWrite), .aAddr(aAddr), .aStrb(aStrb), .aWriteData(aWd),
        .aReadData(aRd[0]), .aReadValid(aRv[0]),
        .bEn(bEn), .bWrite(bWrite), .bAddr(bAddr), .bStrb(bStrb), .bWriteData(bWd),
        .bReadData(bRd[0]), .bReadValid(bRv[0]),
        .conflict(conf[0]), .conflictCount(cnt0)
    );

    dual_port_ram_be #(.AW(8), .DW(32), .SETPRIORITY(0), .READ_LAT(2), .WRITE_FIRST(1), .CW(2)) u1 (
        .clk(clk), .rstN(rstN),
        .aEn(aEn), .aWrite(aWrite), .aAddr(aAddr), .aStrb(aStrb), .aWriteData(aWd),
        .aReadData(aRd[1]), .aReadValid(aRv[1]),
        .bEn(bEn), .bWrite(bWrite), .bAddr(bAddr), .bStrb(bStrb), .bWriteData(bWd),
        .bReadData(bRd[1]), .bReadValid(bRv[1]),
        .conflict(conf[1]), .conflictCount(cnt1)
    );

    // Reference model state, one copy per instance
    logic [31:0] mdl [2][256];
    logic [31:0] heldA [2], heldB [2];
    logic [31:0] pendAd [2], pendBd [2];
    bit          pendAv [2], pendBv [2];
    bit          expAv [2], expBv [2];
    bit          expConf [2];
    int          expCnt [2];

    function automatic logic [31:0] applyW(input logic [31:0] w, input logic [3:0] s,
                                           input logic [31:0] d);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic modelReset(input int k);
        heldA[k] = '0; heldB[k] = '0;
        pendAv[k] = 0; pendBv[k] = 0; pendAd[k] = '0; pendBd[k] = '0;
        expAv[k] = 0; expBv[k] = 0; expConf[k] = 0; expCnt[k] = 0;
    endtask

    // Evaluate one clock edge on the model using the inputs present before the edge.
    task automatic modelStep(input int k);
        logic [31:0] aOldM, bOldM, w, newAd, newBd;
        bit aW, bW, hit, newAv, newBv;
        aW = aEn && aWrite;
        bW = bEn && bWrite;
        aOldM = mdl[k][aAddr];
        bOldM = mdl[k][bAddr];
        hit = 0;
        if (aW && bW && aAddr == bAddr) begin
            // loser's strobes first, winner's strobes overwrite
            if (PRI[k] == 1) w = applyW(applyW(aOldM, aStrb, aWd), bStrb, bWd);
            else             w = applyW(applyW(aOldM, bStrb, bWd), aStrb, aWd);
            mdl[k][aAddr] = w;
            hit = (aStrb & bStrb) != 4'h0;
        end else begin
            if (aW) mdl[k][aAddr] = applyW(aOldM, aStrb, aWd);
            if (bW) mdl[k][bAddr] = applyW(bOldM, bStrb, bWd);
        end
        newAv = aEn && (!aWrite || WF[k] == 1);
        newBv = bEn && (!bWrite || WF[k] == 1);
        newAd = aWrite ? mdl[k][aAddr] : aOldM;
        newBd = bWrite ? mdl[k][bAddr] : bOldM;
        expConf[k] = hit;
        if (hit && expCnt[k] < CMAX[k]) expCnt[k]++;
        if (LAT[k] == 1) begin
            expAv[k] = newAv; if (newAv) heldA[k] = newAd;
            expBv[k] = newBv; if (newBv) heldB[k] = newBd;
        end else begin
            expAv[k] = pendAv[k]; if (pendAv[k]) heldA[k] = pendAd[k];
            expBv[k] = pendBv[k]; if (pendBv[k]) heldB[k] = pendBd[k];
            pendAv[k] = newAv; pendAd[k] = newAd;
            pendBv[k] = newBv; pendBd[k] = newBd;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s u%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic checkOuts(input int k);
        chk("aReadData", k, aRd[k], heldA[k]);
        chk("aReadValid", k, 32'(aRv[k]), 32'(expAv[k]));
        chk("bReadData", k, bRd[k], heldB[k]);
        chk("bReadValid", k, 32'(bRv[k]), 32'(expBv[k]));
        chk("conflict", k, 32'(conf[k]), 32'(expConf[k]));
        chk("conflictCount", k, (k == 0) ? 32'(cnt0) : 32'(cnt1), 32'(expCnt[k]));
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (rstN) modelStep(k);
            else      modelReset(k);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) checkOuts(k);
    endtask

    task automatic setA(input logic en, input logic wr, input logic [7:0] ad,
                        input logic [3:0] st, input logic [31:0] d);
        aEn = en; aWrite = wr; aAddr = ad; aStrb = st; aWd = d;
    endtask

    task automatic setB(input logic en, input logic wr, input logic [7:0] ad,
                        input logic [3:0] st, input logic [31:0] d);
        bEn = en; bWrite = wr; bAddr = ad; bStrb = st; bWd = d;
    endtask

    task automatic idle();
        setA(0, 0, 8'd0, 4'h0, 32'h0);
        setB(0, 0, 8'd0, 4'h0, 32'h0);
    endtask

    task automatic randomAccess(input int addrSpan);
        setA(($urandom % 4) != 0, 1'($urandom), 8'($urandom % addrSpan), 4'($urandom), $urandom);
        setB(($urandom % 4) != 0, 1'($urandom), 8'($urandom % addrSpan), 4'($urandom), $urandom);
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        for (int k = 0; k < 2; k++) modelReset(k);

        // Reset: accesses ignored, outputs zero
        randomAccess(256);
        tick();
        randomAccess(256);
        tick();
        rstN = 1'b1;

        // Populate every word so later reads have defined contents
        for (int i = 0; i < 128; i++) begin
            setA(1, 1, 8'(2 * i), 4'hF, $urandom);
            setB(1, 1, 8'(2 * i + 1), 4'hF, $urandom);
            tick();
        end
        idle();

        // Back-to-back writes then read-back on port A
        for (int i = 0; i < 4; i++) begin
            setA(1, 1, 8'(i), 4'hF, 32'hA000_0000 + 32'(i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            setA(1, 0, 8'(i), 4'h0, 32'h0);
            tick();
            chk("b2b_data", 0, aRd[0], 32'hA000_0000 + 32'(i));
            chk("b2b_valid", 0, 32'(aRv[0]), 32'd1);
        end

        // Byte strobes
        setA(1, 1, 8'd5, 4'hF, 32'hFFFF_FFFF); tick();
        setA(1, 1, 8'd5, 4'b0101, 32'h1234_5678); tick();
        setA(1, 0, 8'd5, 4'h0, 32'h0); tick();
        chk("strobe_merge", 0, aRd[0], 32'hFF34_FF78);
        idle(); tick();
        chk("strobe_merge", 1, aRd[1], 32'hFF34_FF78);

        // Full-overlap collision: u0 gives B priority, u1 gives A priority
        setA(1, 1, 8'd8, 4'hF, 32'hDEAD_BEEF);
        setB(1, 1, 8'd8, 4'hF, 32'hCAFE_BABE);
        tick();
        chk("coll_conflict", 0, 32'(conf[0]), 32'd1);
        chk("coll_count", 0, 32'(cnt0), 32'd1);
        setA(1, 0, 8'd8, 4'h0, 32'h0);
        setB(1, 0, 8'd8, 4'h0, 32'h0);
        tick();
        chk("coll_pulse_end", 0, 32'(conf[0]), 32'd0);
        chk("coll_prio_a", 0, aRd[0], 32'hCAFE_BABE);
        chk("coll_prio_b", 0, bRd[0], 32'hCAFE_BABE);
        idle(); tick();
        chk("coll_prio_a", 1, aRd[1], 32'hDEAD_BEEF);
        chk("coll_prio_b", 1, bRd[1], 32'hDEAD_BEEF);

        // Disjoint lanes merge without conflict
        setA(1, 1, 8'd9, 4'b0011, 32'h1111_1111);
        setB(1, 1, 8'd9, 4'b1100, 32'h2222_2222);
        tick();
        chk("disjoint_conflict", 0, 32'(conf[0]), 32'd0);
        idle();
        setA(1, 0, 8'd9, 4'h0, 32'h0);
        tick();
        chk("disjoint_data", 0, aRd[0], 32'h2222_1111);
        chk("disjoint_count", 0, 32'(cnt0), 32'd1);

        // Read-during-write on one address
        setA(1, 1, 8'd3, 4'hF, 32'h0); setB(0, 0, 8'd0, 4'h0, 32'h0); tick();
        idle(); tick();
        setA(1, 1, 8'd3, 4'hF, 32'h0000_00AA);
        setB(1, 0, 8'd3, 4'h0, 32'h0);
        tick();
        chk("rdw_nowf_valid", 0, 32'(aRv[0]), 32'd0);
        chk("rdw_old_data", 0, bRd[0], 32'h0);
        chk("rdw_lat2_early", 1, 32'(bRv[1]), 32'd0);
        idle(); tick();
        chk("rdw_old_data", 1, bRd[1], 32'h0);
        chk("rdw_old_valid", 1, 32'(bRv[1]), 32'd1);
        chk("rdw_wf_data", 1, aRd[1], 32'h0000_00AA);
        chk("rdw_wf_valid", 1, 32'(aRv[1]), 32'd1);

        // Randomised traffic over a small window to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            randomAccess(8);
            tick();
        end
        idle(); tick(); tick();

        // Counter saturation after a fresh reset
        rstN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            modelReset(k);
            checkOuts(k);
        end
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            setA(1, 1, 8'd10, 4'hF, $urandom);
            setB(1, 1, 8'd10, 4'hF, $urandom);
            tick();
        end
        chk("sat_count", 1, 32'(cnt1), 32'd3);
        chk("nosat_count", 0, 32'(cnt0), 32'd5);
        idle(); tick(); tick();

        // Asynchronous reset with a 2-cycle read in flight
        setA(1, 0, 8'd0, 4'h0, 32'h0);
        tick();
        idle();
        #2;
        rstN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            modelReset(k);
            checkOuts(k);
        end
        randomAccess(16);
        tick();
        rstN = 1'b1;
        idle();
        tick();
        chk("post_reset_valid", 1, 32'(aRv[1]), 32'd0);
        tick();
        chk("post_reset_valid2", 1, 32'(aRv[1]), 32'd0);

        // Traffic resumes cleanly after reset
        for (int n = 0; n < 200; n++) begin
            randomAccess(8);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Second-generation true dual-port synchronous RAM with per-port byte-lane write strobes, a selectable read latency of 1 or 2 cycles, and per-port read-valid flags. Same-address write collisions resolve per byte lane by a priority parameter, and a saturating conflict counter records them. The block sits between two independent masters sharing one storage array on a single clock domain, for example a DMA engine and a CPU.

## Interface
- AW, 8: address width; DEPTH = 2**AW words.
- DW, 32: data width; must be a multiple of 8; NB = DW/8 byte lanes.
- SETPRIORITY, 1: same-address write winner; 0 = port A wins, 1 = port B wins.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2.
- WRITE_FIRST, 0: 0 = a write leaves that port's read data unchanged; 1 = a write returns the merged stored word on that port's read data.
- CW, 16: conflict counter width.

- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- aEn  in  1  port A access enable.
- aWrite  in  1  port A write (1) / read (0); ignored when aEn=0.
- aAddr  in  AW  port A word address.
- aStrb  in  NB  port A byte-lane write strobes; bit i covers bits [8i+7:8i].
- aWriteData  in  DW  port A write data.
- aReadData  out  DW  port A read data.
- aReadValid  out  1  port A read data valid, one-cycle pulse per accepted access.
- bEn, bWrite, bAddr, bStrb, bWriteData, bReadData, bReadValid: port B, identical to port A.
- conflict  out  1  registered pulse for a same-address overlapping write.
- conflictCount  out  CW  saturating count of conflict events.

## Operation
- Every access is accepted on a rising edge where xEn=1. There is no backpressure, and each port can accept one access per cycle.
- Read (xEn=1, xWrite=0): returns mem[xAddr] as it was before this edge's writes from either port. Cross-port reads are always read-first.
- Write (xEn=1, xWrite=1): a lane with xStrb[i]=1 updates byte i of mem[xAddr]. A write with xStrb=0 changes nothing.
  - WRITE_FIRST=0: xReadData holds and xReadValid stays 0.
  - WRITE_FIRST=1: xReadData returns the post-merge stored word and xReadValid pulses.
- Collision (both ports write, aAddr==bAddr):
  - Per lane, the winner's byte is stored if the winner's strobe is set; otherwise the loser's byte is stored if the loser's strobe is set; otherwise the old byte is kept.
  - If (aStrb & bStrb) != 0, conflict=1 on the next cycle and conflictCount increments once, saturating at 2**CW-1.
  - Disjoint strobes merge cleanly with no conflict.
  - In WRITE_FIRST mode, both ports return the same final merged word.
- One port writes and the other reads the same address: the reader gets the old word. This is not a conflict.
- Different addresses: the two ports are fully independent.
- Memory array is not reset; its contents are undefined until written.
- While rstN=0:
  - writes are suppressed and accesses are ignored;
  - all output registers and pipeline stages clear, so in-flight reads are dropped and no valid pulse follows deassertion.

## Timing
- Reset values: aReadData=0, bReadData=0, aReadValid=0, bReadValid=0, conflict=0, conflictCount=0.
- READ_LAT=1: access at edge N gives data and valid after edge N, sampled at edge N+1.
- READ_LAT=2: one extra output register stage, so data and valid appear one cycle later. The pipeline carries back-to-back accesses at full rate.
- xReadData holds its last value when xReadValid=0.
- conflict is registered with 1-cycle latency, aligned with READ_LAT=1 data, and deasserts after one cycle unless the collision repeats.
- conflictCount updates on the same edge that sets conflict.
- Reset deassertion: the first access is accepted at the first rising edge with rstN=1.

## Test plan
- Back-to-back writes:
  - Stimulus: READ_LAT=1; A writes A0000000+i to addr 0..3 with full strobes, then reads them back.
  - Response: aReadValid pulses each cycle and the data matches; aReadData=0 during reset.
- Byte strobes:
  - Stimulus: write FFFFFFFF to addr 5, then write 12345678 with aStrb=0101.
  - Response: read returns FF34FF78.
- Conflict with priority:
  - Stimulus: SETPRIORITY=1; same edge, A writes DEADBEEF and B writes CAFEBABE to addr 8, strobes 1111.
  - Response: both reads return CAFEBABE, conflict pulses one cycle, conflictCount=1.
  - With SETPRIORITY=0, both reads return DEADBEEF.
- Disjoint-lane merge:
  - Stimulus: A writes 11111111 with strobe 0011, B writes 22222222 with strobe 1100, both to addr 9.
  - Response: read returns 22221111, conflict stays 0, count unchanged.
- Read-during-write and latency:
  - Stimulus: READ_LAT=2, WRITE_FIRST=1; addr 3 holds 0; A writes 000000AA to addr 3 while B reads addr 3.
  - Response: B returns 00000000 two cycles later; A returns 000000AA with aReadValid.
  - With WRITE_FIRST=0, aReadValid stays low.
- Reset and saturation:
  - Stimulus: pull rstN low while a READ_LAT=2 read is in flight.
  - Response: no valid pulse follows, and all outputs are 0 asynchronously.
  - Stimulus: with CW=2, force 5 conflicts.
  - Response: conflictCount holds 3.
